// File: rtl/tcm_arb_pkg.sv
// Shared constants for the TCM data-port arbiter: master ids and default sizing.
package tcm_arb_pkg;

  localparam logic M_CORE = 1'b0;
  localparam logic M_AUX  = 1'b1;

  localparam int DEF_OUTSTANDING = 4;
  localparam int DEF_TAG_W       = 11;

endpackage

// File: rtl/arb_id_fifo.sv
// One-bit-wide in-order FIFO holding the id of the master behind each
// outstanding transaction. Pointers wrap naturally because DEPTH is a power of 2.
module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Id storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tcm_dport_arb.sv
// Two-master arbiter for the TCM data port: held-grant round-robin issue,
// in-order response steering through an id FIFO, sticky error on orphan acks.
module tcm_dport_arb
  import tcm_arb_pkg::*;
#(
  parameter int OUTSTANDING = DEF_OUTSTANDING,
  parameter int TAG_W       = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      m0_addr_i,
  input  logic [31:0]      m0_data_wr_i,
  input  logic             m0_rd_i,
  input  logic [3:0]       m0_wr_i,
  input  logic [TAG_W-1:0] m0_req_tag_i,
  output logic             m0_accept_o,
  output logic             m0_ack_o,
  output logic             m0_error_o,
  output logic [TAG_W-1:0] m0_resp_tag_o,
  output logic [31:0]      m0_data_rd_o,
  input  logic [31:0]      m1_addr_i,
  input  logic [31:0]      m1_data_wr_i,
  input  logic             m1_rd_i,
  input  logic [3:0]       m1_wr_i,
  input  logic [TAG_W-1:0] m1_req_tag_i,
  output logic             m1_accept_o,
  output logic             m1_ack_o,
  output logic             m1_error_o,
  output logic [TAG_W-1:0] m1_resp_tag_o,
  output logic [31:0]      m1_data_rd_o,
  output logic [31:0]      s_addr_o,
  output logic [31:0]      s_data_wr_o,
  output logic             s_rd_o,
  output logic [3:0]       s_wr_o,
  output logic [TAG_W-1:0] s_req_tag_o,
  input  logic             s_accept_i,
  input  logic             s_ack_i,
  input  logic             s_error_i,
  input  logic [TAG_W-1:0] s_resp_tag_i,
  input  logic [31:0]      s_data_rd_i,
  output logic             busy_o,
  output logic             err_o
);

  logic req0, req1;
  logic held, held_id, rr_ptr;
  logic has_win, win_id, win_req, issue, accept;
  logic fifo_full, fifo_empty, head, pop;

  assign req0 = m0_rd_i | (|m0_wr_i);
  assign req1 = m1_rd_i | (|m1_wr_i);

  // Winner selection: a held grant sticks until accepted, otherwise round-robin on contention.
  always_comb begin
    has_win = held | req0 | req1;
    if (held)             win_id = held_id;
    else if (req0 & req1) win_id = rr_ptr;
    else                  win_id = req1 ? M_AUX : M_CORE;
    win_req = (win_id == M_AUX) ? req1 : req0;
    issue   = has_win & win_req & ~fifo_full & ~rst;
    accept  = issue & s_accept_i;
  end

  // Downstream request mux; strobes are forced low whenever nothing may issue.
  always_comb begin
    s_addr_o    = (has_win && win_id == M_AUX) ? m1_addr_i    : m0_addr_i;
    s_data_wr_o = (has_win && win_id == M_AUX) ? m1_data_wr_i : m0_data_wr_i;
    s_req_tag_o = (has_win && win_id == M_AUX) ? m1_req_tag_i : m0_req_tag_i;
    s_rd_o      = issue & ((win_id == M_AUX) ? m1_rd_i : m0_rd_i);
    s_wr_o      = issue ? ((win_id == M_AUX) ? m1_wr_i : m0_wr_i) : 4'h0;
    m0_accept_o = accept & (win_id == M_CORE);
    m1_accept_o = accept & (win_id == M_AUX);
  end

  // Response steering: the FIFO head names the master that owns the returning ack.
  always_comb begin
    pop           = s_ack_i & ~fifo_empty & ~rst;
    m0_ack_o      = pop & (head == M_CORE);
    m1_ack_o      = pop & (head == M_AUX);
    m0_error_o    = m0_ack_o & s_error_i;
    m1_error_o    = m1_ack_o & s_error_i;
    m0_resp_tag_o = s_resp_tag_i;
    m1_resp_tag_o = s_resp_tag_i;
    m0_data_rd_o  = s_data_rd_i;
    m1_data_rd_o  = s_data_rd_i;
    busy_o        = ~fifo_empty;
  end

  // Grant hold, round-robin pointer and sticky orphan-ack error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held    <= 1'b0;
      held_id <= M_CORE;
      rr_ptr  <= M_CORE;
      err_o   <= 1'b0;
    end else begin
      if (accept) begin
        held   <= 1'b0;
        rr_ptr <= ~win_id;
      end else if (issue) begin
        held    <= 1'b1;
        held_id <= win_id;
      end
      if (s_ack_i & fifo_empty) err_o <= 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_id_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (pop),
    .din  (win_id),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_tcm_dport_arb.sv
// Bench for tcm_dport_arb: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the arbiter.
module tb_tcm_dport_arb;

  localparam int OUT = 4;
  localparam int TW  = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i;
  logic        m0_rd_i, m1_rd_i;
  logic [3:0]  m0_wr_i, m1_wr_i;
  logic [TW-1:0] m0_req_tag_i, m1_req_tag_i;
  logic        m0_accept_o, m0_ack_o, m0_error_o, m1_accept_o, m1_ack_o, m1_error_o;
  logic [TW-1:0] m0_resp_tag_o, m1_resp_tag_o, s_req_tag_o, s_resp_tag_i;
  logic [31:0] m0_data_rd_o, m1_data_rd_o, s_addr_o, s_data_wr_o, s_data_rd_i;
  logic        s_rd_o, s_accept_i, s_ack_i, s_error_i, busy_o, err_o;
  logic [3:0]  s_wr_o;

  tcm_dport_arb #(.OUTSTANDING(OUT), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_wr_i(m0_data_wr_i), .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i),
    .m0_req_tag_i(m0_req_tag_i), .m0_accept_o(m0_accept_o), .m0_ack_o(m0_ack_o),
    .m0_error_o(m0_error_o), .m0_resp_tag_o(m0_resp_tag_o), .m0_data_rd_o(m0_data_rd_o),
    .m1_addr_i(m1_addr_i), .m1_data_wr_i(m1_data_wr_i), .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i),
    .m1_req_tag_i(m1_req_tag_i), .m1_accept_o(m1_accept_o), .m1_ack_o(m1_ack_o),
    .m1_error_o(m1_error_o), .m1_resp_tag_o(m1_resp_tag_o), .m1_data_rd_o(m1_data_rd_o),
    .s_addr_o(s_addr_o), .s_data_wr_o(s_data_wr_o), .s_rd_o(s_rd_o), .s_wr_o(s_wr_o),
    .s_req_tag_o(s_req_tag_o), .s_accept_i(s_accept_i), .s_ack_i(s_ack_i),
    .s_error_i(s_error_i), .s_resp_tag_i(s_resp_tag_i), .s_data_rd_i(s_data_rd_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  // Master-side pending transactions: a master keeps its request until accepted.
  bit          act[2];
  logic [31:0] maddr[2], mwd[2];
  logic        mrd[2];
  logic [3:0]  mwr[2];
  logic [TW-1:0] mtag[2];

  // Slave-side stimulus for the next cycle.
  bit          s_acc, s_ak, s_er;
  logic [31:0] s_rdat;
  logic [TW-1:0] s_rtag;

  // Reference model: in-flight owner list, locked master (-1 = none), preferred master.
  int q[$];
  int lock  = -1;
  int favor = 0;
  bit err_m = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_txn(input int i, input bit force_wr);
    act[i]   = 1'b1;
    maddr[i] = $urandom;
    mwd[i]   = $urandom;
    mtag[i]  = TW'($urandom);
    mrd[i]   = force_wr ? 1'b0 : 1'($urandom_range(0, 1));
    mwr[i]   = mrd[i] ? 4'h0 : (force_wr ? 4'hF : 4'($urandom_range(1, 15)));
  endtask

  task automatic model_reset();
    q.delete();
    lock  = -1;
    favor = 0;
    err_m = 1'b0;
  endtask

  // One clock: drive at negedge, compare combinational outputs, advance model at posedge.
  task automatic step(input string ph);
    bit has, full, issue, acc;
    int w, ackto;
    @(negedge clk);
    m0_addr_i = maddr[0]; m0_data_wr_i = mwd[0]; m0_req_tag_i = mtag[0];
    m0_rd_i = act[0] & mrd[0]; m0_wr_i = act[0] ? mwr[0] : 4'h0;
    m1_addr_i = maddr[1]; m1_data_wr_i = mwd[1]; m1_req_tag_i = mtag[1];
    m1_rd_i = act[1] & mrd[1]; m1_wr_i = act[1] ? mwr[1] : 4'h0;
    s_accept_i = s_acc; s_ack_i = s_ak; s_error_i = s_er;
    s_data_rd_i = s_rdat; s_resp_tag_i = s_rtag;
    #1;
    has = (lock >= 0) || act[0] || act[1];
    if (lock >= 0)            w = lock;
    else if (act[0] && act[1]) w = favor;
    else                      w = act[1] ? 1 : 0;
    full  = (q.size() >= OUT);
    issue = has && act[w] && !full;
    acc   = issue && s_acc;
    ackto = (s_ak && q.size() > 0) ? q[0] : -1;
    check({ph, ".acc0"}, 64'(m0_accept_o), 64'(acc && w == 0));
    check({ph, ".acc1"}, 64'(m1_accept_o), 64'(acc && w == 1));
    check({ph, ".srd"},  64'(s_rd_o), 64'(issue ? mrd[w] : 1'b0));
    check({ph, ".swr"},  64'(s_wr_o), 64'(issue ? mwr[w] : 4'h0));
    check({ph, ".sadr"}, 64'(s_addr_o), 64'(has ? maddr[w] : maddr[0]));
    if (issue) begin
      check({ph, ".swd"},  64'(s_data_wr_o), 64'(mwd[w]));
      check({ph, ".stag"}, 64'(s_req_tag_o), 64'(mtag[w]));
    end
    check({ph, ".ack0"}, 64'(m0_ack_o), 64'(ackto == 0));
    check({ph, ".ack1"}, 64'(m1_ack_o), 64'(ackto == 1));
    check({ph, ".err0"}, 64'(m0_error_o), 64'(ackto == 0 && s_er));
    check({ph, ".err1"}, 64'(m1_error_o), 64'(ackto == 1 && s_er));
    if (ackto == 0) begin
      check({ph, ".dat0"}, 64'(m0_data_rd_o), 64'(s_rdat));
      check({ph, ".tag0"}, 64'(m0_resp_tag_o), 64'(s_rtag));
    end
    if (ackto == 1) begin
      check({ph, ".dat1"}, 64'(m1_data_rd_o), 64'(s_rdat));
      check({ph, ".tag1"}, 64'(m1_resp_tag_o), 64'(s_rtag));
    end
    check({ph, ".busy"}, 64'(busy_o), 64'(q.size() > 0));
    check({ph, ".perr"}, 64'(err_o), 64'(err_m));
    @(posedge clk);
    if (s_ak && q.size() == 0) err_m = 1'b1;
    if (ackto >= 0) q.delete(0);
    if (acc) begin
      q.push_back(w);
      favor  = 1 - w;
      lock   = -1;
      act[w] = 1'b0;
    end else if (issue) begin
      lock = w;
    end
  endtask

  // Assert reset across one rising edge; outputs must clear while it is high.
  task automatic do_reset(input string ph);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({ph, ".acc0"}, 64'(m0_accept_o), 64'd0);
    check({ph, ".acc1"}, 64'(m1_accept_o), 64'd0);
    check({ph, ".ack0"}, 64'(m0_ack_o), 64'd0);
    check({ph, ".ack1"}, 64'(m1_ack_o), 64'd0);
    check({ph, ".srd"},  64'(s_rd_o), 64'd0);
    check({ph, ".swr"},  64'(s_wr_o), 64'd0);
    check({ph, ".busy"}, 64'(busy_o), 64'd0);
    check({ph, ".perr"}, 64'(err_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; maddr[i] = '0; mwd[i] = '0; mrd[i] = 1'b0; mwr[i] = '0; mtag[i] = '0;
    end
    s_acc = 1'b1; s_ak = 1'b0; s_er = 1'b0; s_rdat = '0; s_rtag = '0;
    m0_addr_i = '0; m0_data_wr_i = '0; m0_rd_i = 1'b0; m0_wr_i = '0; m0_req_tag_i = '0;
    m1_addr_i = '0; m1_data_wr_i = '0; m1_rd_i = 1'b0; m1_wr_i = '0; m1_req_tag_i = '0;
    s_accept_i = 1'b0; s_ack_i = 1'b0; s_error_i = 1'b0; s_data_rd_i = '0; s_resp_tag_i = '0;
    do_reset("rst0");

    // Single read from m0, acked the following cycle.
    act[0] = 1'b1; maddr[0] = 32'h8000_0010; mrd[0] = 1'b1; mwr[0] = 4'h0; mtag[0] = 11'h001;
    step("t1i");
    s_ak = 1'b1; s_rdat = 32'hDEAD_BEEF; s_rtag = 11'h005;
    step("t1a");
    s_ak = 1'b0;
    step("t1d");

    // Both masters requesting continuously, then in-order acks.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) if (!act[i]) new_txn(i, 1'b0);
      step("t2");
    end
    act[0] = 1'b0; act[1] = 1'b0;
    s_ak = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_rdat = $urandom; s_rtag = TW'($urandom);
      step("t2a");
    end
    s_ak = 1'b0;

    // m1 stalls downstream, m0 joins; held grant keeps m1 in front.
    s_acc = 1'b0;
    new_txn(1, 1'b0);
    for (int k = 0; k < 3; k++) step("t3s");
    new_txn(0, 1'b0);
    step("t3b");
    s_acc = 1'b1;
    step("t3g");
    step("t3g");
    s_ak = 1'b1;
    step("t3a");
    step("t3a");
    s_ak = 1'b0;

    // Fill the id FIFO with writes, then free one slot.
    for (int k = 0; k < 5; k++) begin
      if (!act[0]) new_txn(0, 1'b1);
      step("t4f");
    end
    s_ak = 1'b1;
    step("t4p");
    s_ak = 1'b0;
    step("t4n");
    s_ak = 1'b1;
    for (int k = 0; k < 4; k++) step("t4d");
    s_ak = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) if (!act[i] && $urandom_range(0, 1) == 1) new_txn(i, 1'b0);
      s_acc  = ($urandom_range(0, 3) != 0);
      s_ak   = ($urandom_range(0, 2) == 0) && (q.size() > 0 || $urandom_range(0, 30) == 0);
      s_er   = 1'($urandom_range(0, 1));
      s_rdat = $urandom;
      s_rtag = TW'($urandom);
      step("rnd");
    end
    s_ak = 1'b0; s_er = 1'b0; s_acc = 1'b1;

    // Orphan ack with an empty FIFO sets the sticky error.
    act[0] = 1'b0; act[1] = 1'b0;
    do_reset("rst1");
    s_ak = 1'b1;
    step("t5a");
    s_ak = 1'b0;
    for (int k = 0; k < 3; k++) step("t5h");

    // Reset with two transactions in flight, then a stale ack.
    do_reset("rst2");
    new_txn(0, 1'b0);
    new_txn(1, 1'b0);
    step("t6i");
    step("t6i");
    check("t6.busy", 64'(busy_o), 64'd1);
    do_reset("rst3");
    s_ak = 1'b1;
    step("t6s");
    s_ak = 1'b0;
    step("t6e");
    check("t6.err", 64'(err_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcm_dport_arb.md
Name: tcm_dport_arb

Overview:
- Two-master arbiter for the TCM data port, sitting between the riscv_core data interface (master 0) and a second data master (master 1, e.g. debug/DMA) on one side, and the tcm_mem data port on the other.
- Arbitrates request issue with a held-grant round-robin policy.
- Tracks outstanding transactions in an ID FIFO and steers each in-order ack/response back to the master that issued it.
- Cache-maintenance signals (cacheable/invalidate/writeback/flush) are not routed; both masters are treated as uncached.

Parameters:
- OUTSTANDING, 4, max in-flight transactions; ID FIFO depth; power of 2, minimum 2.
- TAG_W, 11, request/response tag width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- mN_addr_i  in  32  master N address (N = 0, 1; applies to every mN_ line below)
- mN_data_wr_i  in  32  write data
- mN_rd_i  in  1  read request
- mN_wr_i  in  4  byte write strobes
- mN_req_tag_i  in  TAG_W  request tag
- mN_accept_o  out  1  request accepted this cycle
- mN_ack_o  out  1  response valid
- mN_error_o  out  1  response error
- mN_resp_tag_o  out  TAG_W  response tag
- mN_data_rd_o  out  32  read data
- s_addr_o, s_data_wr_o, s_rd_o, s_wr_o, s_req_tag_o  out  32/32/1/4/TAG_W  request to tcm_mem
- s_accept_i, s_ack_i, s_error_i  in  1 each  tcm_mem handshake
- s_resp_tag_i  in  TAG_W  response tag from tcm_mem
- s_data_rd_i  in  32  read data from tcm_mem
- busy_o  out  1  ID FIFO non-empty
- err_o  out  1  sticky protocol error

Behaviour:
- Request: reqN = mN_rd_i | (|mN_wr_i).
- Arbitration (combinational):
  - If a grant is held, the held master wins.
  - Otherwise, the only requester wins; if both request, the master indicated by rr_ptr wins.
- Issue path:
  - s_* driven from the winner, gated by !fifo_full.
  - s_rd_o and s_wr_o are 0 when there is no winner or the FIFO is full.
  - s_addr_o/s_data_wr_o/s_req_tag_o follow the winner, else master 0.
  - Zero added request latency.
- Accept: mN_accept_o = winner==N & !fifo_full & s_accept_i. The FIFO-full check uses the registered count only; a same-cycle pop does not free a slot.
- Grant hold register:
  - Set (held=1, held_id=winner) when the winner's request is presented and not accepted.
  - Cleared on acceptance.
  - Prevents switching masters while the downstream is stalled.
- rr_ptr:
  - Reset value 0 (favour m0).
  - On every accept, rr_ptr <= ~accepted_id.
- ID FIFO:
  - Push the accepted master id on accept.
  - Pop the head on s_ack_i.
  - Push and pop in the same cycle are legal (count unchanged).
- Response routing (combinational, zero latency):
  - mN_ack_o = s_ack_i & !fifo_empty & head==N.
  - mN_error_o = s_error_i & that same condition.
  - mN_resp_tag_o and mN_data_rd_o are driven from s_* for both masters; only ack qualifies them.
- Writes are acked by tcm_mem, so reads and writes pop identically.
- err_o: set when s_ack_i arrives with the FIFO empty; that ack is dropped, no mN_ack_o. Cleared only by rst.
- busy_o = !fifo_empty.
- Reset (async, rst=1): FIFO empty, held=0, rr_ptr=0, err_o=0; all *_accept_o/*_ack_o/*_error_o = 0; s_rd_o=0, s_wr_o=0.
- Reset mid-operation: in-flight IDs are discarded; acks arriving after reset set err_o.
- Master protocol: an unaccepted master must hold its request stable; the arbiter never withdraws a held grant.

Decomposition:
- Package tcm_arb_pkg: master-id constants M_CORE=0 and M_AUX=1, default OUTSTANDING, TAG_W.
- Sub-module arb_id_fifo:
  - 1-bit-wide synchronous FIFO, depth OUTSTANDING.
  - Ports: push, pop, din, dout (head), full, empty; log2(depth)+1-bit count.
  - Same clk/rst.

Test Plan:
- Only m0 reads 0x80000010 with s_accept_i=1 and tcm acks next cycle with 0xDEADBEEF, tag 0x005 → m0_accept_o in issue cycle; m0_ack_o=1 with data 0xDEADBEEF, tag 0x005; m1_ack_o=0; busy_o returns to 0.
- m0 and m1 request continuously from reset for 4 cycles, s_accept_i=1 → accepts alternate m0, m1, m0, m1; acks returned in order route to m0, m1, m0, m1.
- m1 requests while s_accept_i=0 for 3 cycles, then m0 also requests, then s_accept_i=1 → m1 accepted first (grant held), m0 next; s_addr_o stays at m1's address throughout the stall.
- m0 issues 4 writes (wr=4'hF) with no acks, OUTSTANDING=4 → fifth request not forwarded (s_wr_o=0, m0_accept_o=0); after one ack, next accept occurs the following cycle.
- s_ack_i pulsed with FIFO empty → no mN_ack_o; err_o=1 and stays 1 until rst.
- Two requests outstanding, assert rst for 1 cycle → all outputs 0 immediately, busy_o=0, rr_ptr=0; a stale s_ack_i afterwards sets err_o.
